// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2,
    HOLD    = 2'd3
  } fetch_state_e;

  localparam logic [1:0]  PCSRC_SEQ   = 2'b00;
  localparam logic [1:0]  PCSRC_BR    = 2'b01;
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry {pc, instr, valid} buffer that parks an acked word while the pipe is stalled.
module fetch_hold_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_instr,
  output logic [31:0] q_pc,
  output logic [31:0] q_instr,
  output logic        q_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_pc    <= 32'h0;
      q_instr <= NOP_DEFAULT;
      q_valid <= 1'b0;
    end else if (load) begin
      q_pc    <= d_pc;
      q_instr <= d_instr;
      q_valid <= 1'b1;
    end else if (clear) begin
      q_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, drives the req/ack imem port and loads IF/ID.
// Optional performance counters are built when FETCH_PERF_EN is defined.
//
// state   | meaning
// IDLE    | after reset, no request
// REQ     | request for pc outstanding
// DISCARD | stale request outstanding, pc replaced by pending_pc on ack
// HOLD    | acked word parked in the hold buffer while Stall is high
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] Branch_target,
  input  logic        Stall,
  input  logic        Flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_instr,
  output logic        IF_ID_valid,
  output logic        fetch_busy
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall_cyc
`endif
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, pc_nxt, pending_pc, pending_nxt, tgt;
  logic         redirect, deliver, hb_load, hb_clear, hb_valid;
  logic [31:0]  del_pc, del_instr, hb_pc, hb_instr;

  assign redirect   = (PCSrc == PCSRC_BR);
  assign tgt        = word_align(Branch_target);
  assign imem_req   = (state == REQ) || (state == DISCARD);
  assign imem_addr  = pc;
  assign fetch_busy = imem_req;

  fetch_hold_buf u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .load    (hb_load),
    .clear   (hb_clear),
    .d_pc    (pc),
    .d_instr (imem_rdata),
    .q_pc    (hb_pc),
    .q_instr (hb_instr),
    .q_valid (hb_valid)
  );

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    pending_nxt = pending_pc;
    hb_load     = 1'b0;
    hb_clear    = 1'b0;
    deliver     = 1'b0;
    del_pc      = pc;
    del_instr   = imem_rdata;
    case (state)
      IDLE: begin
        state_nxt = REQ;
        if (redirect) pc_nxt = tgt;
      end
      REQ: begin
        if (imem_ack) begin
          if (redirect) begin
            pc_nxt = tgt;
          end else if (Stall) begin
            hb_load   = 1'b1;
            state_nxt = HOLD;
          end else begin
            deliver = 1'b1;
            pc_nxt  = pc + 32'd4;
          end
        end else if (redirect) begin
          pending_nxt = tgt;
          state_nxt   = DISCARD;
        end
      end
      DISCARD: begin
        // A redirect coinciding with the stale ack is the newest target.
        if (redirect) pending_nxt = tgt;
        if (imem_ack) begin
          pc_nxt    = redirect ? tgt : pending_pc;
          state_nxt = REQ;
        end
      end
      HOLD: begin
        if (redirect) begin
          hb_clear  = 1'b1;
          pc_nxt    = tgt;
          state_nxt = REQ;
        end else if (!Stall && hb_valid) begin
          deliver   = 1'b1;
          del_pc    = hb_pc;
          del_instr = hb_instr;
          hb_clear  = 1'b1;
          pc_nxt    = hb_pc + 32'd4;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      pending_pc <= RESET_PC;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      pending_pc <= pending_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      IF_ID_pc    <= 32'h0;
      IF_ID_instr <= NOP_INSTR;
      IF_ID_valid <= 1'b0;
    end else if (redirect || Flush) begin
      IF_ID_instr <= NOP_INSTR;
      IF_ID_valid <= 1'b0;
    end else if (Stall) begin
      IF_ID_valid <= IF_ID_valid;
    end else if (deliver) begin
      IF_ID_pc    <= del_pc;
      IF_ID_instr <= del_instr;
      IF_ID_valid <= 1'b1;
    end else begin
      IF_ID_instr <= NOP_INSTR;
      IF_ID_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  logic accepted, entered;
  assign accepted = (state == REQ) && imem_ack && !redirect;
  assign entered  = deliver && !redirect && !Flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched   <= 32'h0;
      perf_stall_cyc <= 32'h0;
    end else begin
      if (accepted) perf_fetched <= perf_fetched + 32'd1;
      if ((state != IDLE) && !entered) perf_stall_cyc <= perf_stall_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner sequences,
// then randomized traffic against an instruction-stream reference model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  PCSrc;
  logic [31:0] Branch_target;
  logic        Stall, Flush, imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req, IF_ID_valid, fetch_busy;
  logic [31:0] imem_addr, IF_ID_pc, IF_ID_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall_cyc;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .PCSrc         (PCSrc),
    .Branch_target (Branch_target),
    .Stall         (Stall),
    .Flush         (Flush),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .IF_ID_pc      (IF_ID_pc),
    .IF_ID_instr   (IF_ID_instr),
    .IF_ID_valid   (IF_ID_valid),
    .fetch_busy    (fetch_busy)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_stall_cyc(perf_stall_cyc)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        ack, stall, flush;
    logic [1:0]  pcsrc;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        chk_pc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic ack, stall, flush, input logic [1:0] pcsrc, input logic [31:0] tgt,
                     input logic e_req, input logic [31:0] e_addr, input logic e_v,
                     input logic [31:0] e_pc, input logic chk_pc);
    vec_t v;
    v = '{ack, stall, flush, pcsrc, tgt, e_req, e_addr, e_v, e_pc,
          (e_v ? mem_word(e_pc) : NOP), chk_pc};
    tbl.push_back(v);
  endtask

  task automatic drive(input logic ack, stall, flush, input logic [1:0] pcsrc, input logic [31:0] tgt);
    imem_ack = ack; Stall = stall; Flush = flush; PCSrc = pcsrc; Branch_target = tgt;
  endtask

  logic [31:0] exp_pc, prev_addr;
  logic        prev_hold, prev_req_wait, checking, red;
  int          lat, delivered, r;

  initial begin
    //   ack stl fl pcsrc  tgt            req addr          v  if_pc       chk_pc
    add(0, 0, 0, 2'b00, 32'h0,         0, 32'h0000_0000, 0, 32'h0,     1); // reset / IDLE
    add(1, 0, 0, 2'b00, 32'h0,         1, 32'h0000_0000, 0, 32'h0,     0);
    add(1, 0, 0, 2'b10, 32'h0,         1, 32'h0000_0004, 1, 32'h0,     1);
    add(1, 0, 0, 2'b11, 32'h0,         1, 32'h0000_0008, 1, 32'h4,     1);
    add(0, 0, 0, 2'b00, 32'h0,         1, 32'h0000_000C, 1, 32'h8,     1); // 3-cycle latency
    add(0, 0, 0, 2'b00, 32'h0,         1, 32'h0000_000C, 0, 32'h0,     0);
    add(0, 0, 0, 2'b00, 32'h0,         1, 32'h0000_000C, 0, 32'h0,     0);
    add(1, 0, 0, 2'b00, 32'h0,         1, 32'h0000_000C, 0, 32'h0,     0);
    add(0, 0, 0, 2'b01, 32'h100,       1, 32'h0000_0010, 1, 32'hC,     1); // redirect while waiting
    add(0, 0, 0, 2'b00, 32'h0,         1, 32'h0000_0010, 0, 32'h0,     0);
    add(1, 0, 0, 2'b00, 32'h0,         1, 32'h0000_0010, 0, 32'h0,     0); // stale ack dropped
    add(1, 1, 0, 2'b00, 32'h0,         1, 32'h0000_0100, 0, 32'h0,     0); // ack under stall
    add(0, 1, 0, 2'b00, 32'h0,         0, 32'h0000_0100, 0, 32'h0,     0);
    add(0, 0, 0, 2'b00, 32'h0,         0, 32'h0000_0100, 0, 32'h0,     0);
    add(0, 1, 1, 2'b00, 32'h0,         1, 32'h0000_0104, 1, 32'h100,   1); // flush + stall
    add(1, 0, 0, 2'b00, 32'h0,         1, 32'h0000_0104, 0, 32'h100,   1);
    add(1, 0, 0, 2'b01, 32'h203,       1, 32'h0000_0108, 1, 32'h104,   1); // redirect on ack
    add(0, 0, 0, 2'b00, 32'h0,         1, 32'h0000_0200, 0, 32'h0,     0);

    rst = 1'b1;
    drive(0, 0, 0, 2'b00, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      if (i != 0) @(negedge clk);
      check($sformatf("v%0d_req", i), imem_req, tbl[i].e_req);
      check($sformatf("v%0d_busy", i), fetch_busy, tbl[i].e_req);
      check($sformatf("v%0d_addr", i), imem_addr, tbl[i].e_addr);
      check($sformatf("v%0d_valid", i), IF_ID_valid, tbl[i].e_v);
      check($sformatf("v%0d_instr", i), IF_ID_instr, tbl[i].e_instr);
      if (tbl[i].chk_pc) check($sformatf("v%0d_ifpc", i), IF_ID_pc, tbl[i].e_pc);
      drive(tbl[i].ack, tbl[i].stall, tbl[i].flush, tbl[i].pcsrc, tbl[i].tgt);
    end

    // Wrap of the sequential PC.
    @(negedge clk);
    drive(1, 0, 0, 2'b01, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    drive(1, 0, 0, 2'b00, 32'h0);
    @(negedge clk);
    check("wrap_addr1", imem_addr, 32'h0000_0000);
    check("wrap_ifpc", IF_ID_pc, 32'hFFFF_FFFC);
    check("wrap_instr", IF_ID_instr, mem_word(32'hFFFF_FFFC));
    check("wrap_valid", IF_ID_valid, 1'b1);
    drive(0, 0, 0, 2'b00, 32'h0);

    // Reset asserted mid-request, then a stale ack while idle.
    @(negedge clk);
    check("midrst_req_before", imem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midrst_req", imem_req, 1'b0);
    check("midrst_busy", fetch_busy, 1'b0);
    check("midrst_addr", imem_addr, 32'h0);
    check("midrst_valid", IF_ID_valid, 1'b0);
`ifdef FETCH_PERF_EN
    check("midrst_perf_fetched", perf_fetched, 32'h0);
    check("midrst_perf_stall", perf_stall_cyc, 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    check("stale_req", imem_req, 1'b1);
    check("stale_addr", imem_addr, 32'h0);
    check("stale_valid", IF_ID_valid, 1'b0);
    @(negedge clk);
    check("stale_addr2", imem_addr, 32'h0);
    check("stale_valid2", IF_ID_valid, 1'b0);

    // Randomized traffic: every valid IF/ID entry must continue the expected
    // instruction stream (pc+4 sequence restarted at each redirect target).
    checking = 1'b0; prev_hold = 1'b0; prev_req_wait = 1'b0; prev_addr = 32'h0;
    exp_pc = 32'h0; delivered = 0; lat = $urandom_range(0, 3);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (checking) begin
        if (prev_req_wait) begin
          check("rnd_req_held", imem_req, 1'b1);
          check("rnd_addr_stable", imem_addr, prev_addr);
        end
        if (!prev_hold && IF_ID_valid) begin
          check("rnd_stream_pc", IF_ID_pc, exp_pc);
          check("rnd_stream_instr", IF_ID_instr, mem_word(exp_pc));
          exp_pc = exp_pc + 32'd4;
          delivered++;
        end
      end
      Stall = ($urandom_range(0, 3) == 0);
      red = (cyc == 0) || ($urandom_range(0, 15) == 0);
      r = $urandom_range(0, 2);
      PCSrc = red ? PCSRC_BR : (r == 0) ? PCSRC_SEQ : (r == 1) ? 2'b10 : 2'b11;
      Branch_target = $urandom;
      Flush = (red || Stall) && ($urandom_range(0, 1) == 1);
      if (imem_req) begin
        if (lat == 0) begin
          imem_ack = 1'b1;
          lat = $urandom_range(0, 3);
        end else begin
          imem_ack = 1'b0;
          lat--;
        end
      end else begin
        imem_ack = 1'b0;
      end
      if (red) exp_pc = Branch_target & 32'hFFFF_FFFC;
      prev_hold = Stall && !red && !Flush;
      prev_req_wait = imem_req && !imem_ack;
      prev_addr = imem_addr;
      checking = 1'b1;
    end
    check("rnd_progress", 32'(delivered >= 200), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
